// File: rtl/sphere_scheduler.sv
// Shares one combinational sphere intersection unit across NUM_SPHERES slots:
// each accepted ray is tested against every slot in turn and the nearest enabled hit colours the pixel.
module sphere_scheduler #(
   parameter int          NUM_SPHERES = 4,
   parameter logic [31:0] BACKGROUND  = 32'h000000ff,
   localparam int         SW          = $clog2(NUM_SPHERES)
) (
   input  logic          pixel_clk,
   input  logic          reset,
   input  logic          ray_valid,
   output logic          ray_ready,
   input  logic [47:0]   ray_in,
   output logic [47:0]   isect_ray,
   output logic [47:0]   isect_center,
   output logic [15:0]   isect_radius,
   input  logic          isect_hit,
   input  logic [15:0]   isect_dist,
   input  logic          cfg_we,
   input  logic [SW-1:0] cfg_slot,
   input  logic [2:0]    cfg_field,
   input  logic [31:0]   cfg_wdata,
   output logic          pixel_valid,
   input  logic          pixel_ready,
   output logic [31:0]   pixel_data,
   output logic          busy
);

   // Handshakes: a ray transfers on a rising edge where ray_valid && ray_ready;
   // a pixel transfers on a rising edge where pixel_valid && pixel_ready.
   // pixel_data is held stable from the first cycle pixel_valid is high until it transfers.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Slot configuration registers
   logic [15:0]            radius_q [NUM_SPHERES];
   logic [15:0]            cx_q     [NUM_SPHERES];
   logic [15:0]            cy_q     [NUM_SPHERES];
   logic [15:0]            cz_q     [NUM_SPHERES];
   logic [31:0]            colour_q [NUM_SPHERES];
   logic [NUM_SPHERES-1:0] enable_q;

   // Scan datapath
   logic [SW-1:0] slot_cnt;
   logic [15:0]   best_dist;
   logic [31:0]   best_colour;
   logic          found;
   logic          last_slot;
   logic          take;

   assign last_slot = (slot_cnt == SW'(NUM_SPHERES - 1));

   // Strict less-than keeps the earlier (lower index) slot on equal distance.
   assign take = (state == SCAN) && enable_q[slot_cnt] && isect_hit &&
                 (!found || (isect_dist < best_dist));

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPHERES; i++) begin
            radius_q[i] <= 16'h0000;
            cx_q[i]     <= 16'h0000;
            cy_q[i]     <= 16'h0000;
            cz_q[i]     <= 16'h0000;
            colour_q[i] <= 32'hff0000ff;
         end
         enable_q <= '0;
      end else if (cfg_we) begin
         case (cfg_field)
            3'd0:    radius_q[cfg_slot] <= cfg_wdata[15:0];
            3'd1:    cx_q[cfg_slot]     <= cfg_wdata[15:0];
            3'd2:    cy_q[cfg_slot]     <= cfg_wdata[15:0];
            3'd3:    cz_q[cfg_slot]     <= cfg_wdata[15:0];
            3'd4:    colour_q[cfg_slot] <= cfg_wdata;
            3'd5:    enable_q[cfg_slot] <= cfg_wdata[0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ray_valid) state_next = SCAN;
         SCAN:    if (last_slot) state_next = EMIT;
         EMIT:    if (pixel_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ray_ready    = (state == IDLE) && !reset;
      pixel_valid  = (state == EMIT);
      busy         = (state != IDLE);
      isect_center = 48'h0;
      isect_radius = 16'h0;
      if (state == SCAN) begin
         isect_center = {cz_q[slot_cnt], cy_q[slot_cnt], cx_q[slot_cnt]};
         isect_radius = radius_q[slot_cnt];
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         isect_ray   <= 48'h0;
         slot_cnt    <= '0;
         best_dist   <= 16'hffff;
         best_colour <= BACKGROUND;
         found       <= 1'b0;
         pixel_data  <= BACKGROUND;
      end else begin
         case (state)
            IDLE: begin
               if (ray_valid) begin
                  isect_ray   <= ray_in;
                  slot_cnt    <= '0;
                  best_dist   <= 16'hffff;
                  best_colour <= BACKGROUND;
                  found       <= 1'b0;
               end
            end
            SCAN: begin
               slot_cnt <= slot_cnt + SW'(1);
               if (take) begin
                  best_dist   <= isect_dist;
                  best_colour <= colour_q[slot_cnt];
                  found       <= 1'b1;
               end
               // The final slot's own result must be folded in before the pixel is registered.
               if (last_slot) begin
                  pixel_data <= take ? colour_q[slot_cnt] : best_colour;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sphere_scheduler.sv
// Self-checking bench for sphere_scheduler: a keyed intersection-unit model, a config shadow,
// and a scoreboard of expected pixels pushed at ray acceptance and popped at pixel handoff.
module tb_sphere_scheduler;

   localparam int          N  = 4;
   localparam int          SW = $clog2(N);
   localparam logic [31:0] BG = 32'h000000ff;

   logic          pixel_clk;
   logic          reset;
   logic          ray_valid;
   logic          ray_ready;
   logic [47:0]   ray_in;
   logic [47:0]   isect_ray;
   logic [47:0]   isect_center;
   logic [15:0]   isect_radius;
   logic          isect_hit;
   logic [15:0]   isect_dist;
   logic          cfg_we;
   logic [SW-1:0] cfg_slot;
   logic [2:0]    cfg_field;
   logic [31:0]   cfg_wdata;
   logic          pixel_valid;
   logic          pixel_ready;
   logic [31:0]   pixel_data;
   logic          busy;

   sphere_scheduler #(.NUM_SPHERES(N), .BACKGROUND(BG)) dut (
      .pixel_clk    (pixel_clk),
      .reset        (reset),
      .ray_valid    (ray_valid),
      .ray_ready    (ray_ready),
      .ray_in       (ray_in),
      .isect_ray    (isect_ray),
      .isect_center (isect_center),
      .isect_radius (isect_radius),
      .isect_hit    (isect_hit),
      .isect_dist   (isect_dist),
      .cfg_we       (cfg_we),
      .cfg_slot     (cfg_slot),
      .cfg_field    (cfg_field),
      .cfg_wdata    (cfg_wdata),
      .pixel_valid  (pixel_valid),
      .pixel_ready  (pixel_ready),
      .pixel_data   (pixel_data),
      .busy         (busy)
   );

   // ---------------- clock / reset ----------------
   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Intersection-unit model: slot identity is the low nibble of the centre x coordinate.
   logic [15:0] hit_m;
   logic [15:0] dist_m [16];

   always_comb begin
      isect_hit  = hit_m[isect_center[3:0]];
      isect_dist = dist_m[isect_center[3:0]];
   end

   // Config shadow
   logic [15:0] rad_m [N];
   logic [15:0] cx_m  [N];
   logic [31:0] col_m [N];
   logic [N-1:0] en_m;

   // Scoreboard
   logic [31:0] exp_q[$];
   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic shadow_reset();
      for (int i = 0; i < N; i++) begin
         rad_m[i] = 16'h0;
         cx_m[i]  = 16'h0;
         col_m[i] = 32'hff0000ff;
      end
      en_m = '0;
   endtask

   function automatic logic [31:0] exp_pixel();
      logic [15:0] bd = 16'hffff;
      logic        f  = 1'b0;
      logic [31:0] c  = BG;
      logic [3:0]  key;
      for (int k = 0; k < N; k++) begin
         key = cx_m[k][3:0];
         if (en_m[k] && hit_m[key] && (!f || dist_m[key] < bd)) begin
            bd = dist_m[key];
            f  = 1'b1;
            c  = col_m[k];
         end
      end
      return c;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cfg_write(input int slot, input logic [2:0] field, input logic [31:0] data);
      cfg_we    = 1'b1;
      cfg_slot  = SW'(slot);
      cfg_field = field;
      cfg_wdata = data;
      case (field)
         3'd0:    rad_m[slot] = data[15:0];
         3'd1:    cx_m[slot]  = data[15:0];
         3'd4:    col_m[slot] = data;
         3'd5:    en_m[slot]  = data[0];
         default: ;
      endcase
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic send_ray(input logic [47:0] r);
      int w = 0;
      ray_in    = r;
      ray_valid = 1'b1;
      while (!ray_ready && w < 50) begin
         tick();
         w++;
      end
      check("ray_ready_wait", 48'(ray_ready), 48'd1);
      exp_q.push_back(exp_pixel());
      tick();
      ray_valid = 1'b0;
      check("isect_ray", isect_ray, r);
      check("rad_slot0", 48'(isect_radius), 48'(rad_m[0]));
      check("busy_scan", 48'(busy), 48'd1);
   endtask

   task automatic wait_valid();
      int cyc = 0;
      while (cyc < 50) begin
         tick();
         cyc++;
         if (pixel_valid) break;
      end
      check("latency", 48'(cyc), 48'(N));
   endtask

   task automatic take_pixel();
      logic [31:0] e;
      check("sb_nonempty", 48'(exp_q.size() != 0), 48'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
      check("pixel_data", 48'(pixel_data), 48'(e));
      pixel_ready = 1'b1;
      tick();
      pixel_ready = 1'b0;
      check("valid_drop", 48'(pixel_valid), 48'd0);
      check("idle_ready", 48'(ray_ready), 48'd1);
   endtask

   task automatic run_ray(input logic [47:0] r);
      send_ray(r);
      wait_valid();
      take_pixel();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] held;
      reset       = 1'b1;
      ray_valid   = 1'b0;
      ray_in      = 48'h0;
      cfg_we      = 1'b0;
      cfg_slot    = '0;
      cfg_field   = 3'd0;
      cfg_wdata   = 32'h0;
      pixel_ready = 1'b0;
      hit_m       = 16'h0;
      for (int i = 0; i < 16; i++) dist_m[i] = 16'hffff;
      shadow_reset();
      repeat (3) tick();
      reset = 1'b0;
      repeat (5) tick();

      // Reset state
      check("rst_ray_ready", 48'(ray_ready), 48'd1);
      check("rst_pixel_valid", 48'(pixel_valid), 48'd0);
      check("rst_pixel_data", 48'(pixel_data), 48'(BG));
      check("rst_busy", 48'(busy), 48'd0);
      check("rst_isect_ray", isect_ray, 48'h0);
      check("rst_center", isect_center, 48'h0);
      check("rst_radius", 48'(isect_radius), 48'h0);

      // Single enabled slot hit
      cfg_write(0, 3'd0, 32'h3800);
      cfg_write(0, 3'd3, 32'h4000);
      cfg_write(0, 3'd5, 32'h1);
      hit_m[0] = 1'b1;
      dist_m[0] = 16'h0800;
      run_ray({16'h2000, 16'h0000, 16'h0000});
      check("t2_colour", 48'(pixel_data), 48'hff0000ff);

      // Nearest of two, then tie goes to lower slot
      hit_m[0] = 1'b0;
      cfg_write(1, 3'd1, 32'h1);
      cfg_write(2, 3'd1, 32'h2);
      cfg_write(1, 3'd4, 32'h00ff00ff);
      cfg_write(2, 3'd4, 32'h0000ffff);
      cfg_write(1, 3'd5, 32'h1);
      cfg_write(2, 3'd5, 32'h1);
      hit_m[1] = 1'b1; dist_m[1] = 16'h1000;
      hit_m[2] = 1'b1; dist_m[2] = 16'h0C00;
      run_ray({16'h1111, 16'h2222, 16'h3333});
      check("t3_near", 48'(exp_pixel()), 48'h0000ffff);
      dist_m[1] = 16'h0C00;
      run_ray({16'h0123, 16'h4567, 16'h89ab});
      check("t3_tie", 48'(exp_pixel()), 48'h00ff00ff);

      // Ignored field: writing field 6/7 must not disturb slot 1
      cfg_write(1, 3'd6, 32'hdeadbeef);
      cfg_write(1, 3'd7, 32'h0);
      run_ray({16'h0001, 16'h0002, 16'h0003});

      // Hits everywhere, all disabled -> background
      hit_m = 16'hffff;
      for (int i = 0; i < 16; i++) dist_m[i] = 16'h0100;
      for (int s = 0; s < N; s++) cfg_write(s, 3'd5, 32'h0);
      run_ray({16'h0004, 16'h0005, 16'h0006});

      // Backpressure in EMIT with a pending ray
      cfg_write(3, 3'd1, 32'h3);
      cfg_write(3, 3'd4, 32'hcafe01ff);
      cfg_write(3, 3'd5, 32'h1);
      send_ray({16'h0aaa, 16'h0bbb, 16'h0ccc});
      wait_valid();
      held = pixel_data;
      ray_in    = {16'h0ddd, 16'h0eee, 16'h0fff};
      ray_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid", 48'(pixel_valid), 48'd1);
         check("bp_data", 48'(pixel_data), 48'(held));
         check("bp_ray_ready", 48'(ray_ready), 48'd0);
      end
      check("bp_isect_ray", isect_ray, {16'h0aaa, 16'h0bbb, 16'h0ccc});
      take_pixel();
      exp_q.push_back(exp_pixel());
      tick();
      ray_valid = 1'b0;
      check("bp_pending_acc", isect_ray, {16'h0ddd, 16'h0eee, 16'h0fff});
      check("bp_busy", 48'(busy), 48'd1);
      wait_valid();
      take_pixel();

      // Reset in the second SCAN cycle
      send_ray({16'h0100, 16'h0200, 16'h0300});
      tick();
      reset = 1'b1;
      #1;
      check("rst_mid_ready", 48'(ray_ready), 48'd0);
      tick();
      reset = 1'b0;
      void'(exp_q.pop_back());
      shadow_reset();
      check("rst_mid_valid", 48'(pixel_valid), 48'd0);
      check("rst_mid_busy", 48'(busy), 48'd0);
      check("rst_mid_data", 48'(pixel_data), 48'(BG));
      repeat (N + 2) begin
         tick();
         check("rst_no_pixel", 48'(pixel_valid), 48'd0);
      end
      run_ray({16'h0700, 16'h0800, 16'h0900});
      check("rst_bg", 48'(exp_pixel()), 48'(BG));

      // Randomised configurations with small distance range to provoke ties
      for (int it = 0; it < 10; it++) begin
         for (int s = 0; s < N; s++) begin
            cfg_write(s, 3'd1, 32'($urandom_range(0, 15)));
            cfg_write(s, 3'd0, 32'($urandom_range(0, 16'hffff)));
            cfg_write(s, 3'd4, $urandom());
            cfg_write(s, 3'd5, 32'($urandom_range(0, 1)));
         end
         hit_m = 16'($urandom_range(0, 16'hffff));
         for (int i = 0; i < 16; i++) dist_m[i] = 16'($urandom_range(0, 3)) << 12;
         run_ray({16'($urandom()), 16'($urandom()), 16'($urandom())});
      end

      check("sb_drained", 48'(exp_q.size()), 48'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
